tod_counter: RTL and testbench

Parametrised time-of-day core: a seconds timestamp counting 0 to SEC_PER_DAY-1 (0 = 12:00:00 AM), with a prescaler from the system clock, a set-time handshake, and N independent alarm channels with ring timeout. It replaces the fixed single-alarm counter/alarm pair. It feeds the coordination module, and through it the output formatter.

---
 rtl/tod_pkg.sv | 32 +++
 rtl/tod_alarm_ch.sv | 122 ++++++++++++
 rtl/tod_counter.sv | 118 +++++++++++
 tb/tb_tod_counter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tod_pkg.sv
// Time-of-day shared definitions: default day length, counter/alarm vector types, alarm FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a. CLOCK_SNOOZE_EN adds the SNOOZED encoding.
package tod_pkg;

    localparam int TOD_SEC_PER_DAY = 86400;
    localparam int TOD_N_ALARMS    = 2;

    typedef logic [$clog2(TOD_SEC_PER_DAY)-1:0] COUNTER_T;
    typedef logic [TOD_N_ALARMS-1:0]            ALARM_T;

`ifdef CLOCK_SNOOZE_EN
    typedef enum logic [1:0] {
        ALM_IDLE    = 2'd0,
        ALM_ARMED   = 2'd1,
        ALM_RINGING = 2'd2,
        ALM_SNOOZED = 2'd3
    } alm_state_e;
`else
    typedef enum logic [1:0] {
        ALM_IDLE    = 2'd0,
        ALM_ARMED   = 2'd1,
        ALM_RINGING = 2'd2
    } alm_state_e;
`endif

    // Index width that never collapses to zero bits for a single entry.
    function automatic int max1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tod_alarm_ch.sv
// One alarm channel: setpoint, IDLE/ARMED/RINGING (+SNOOZED with CLOCK_SNOOZE_EN) FSM, ring timer, snooze target.
// Latency: ringing_o rises/falls one cycle after the registered tick/ack/write that causes it.
// Backpressure: none; writes, acks and snoozes are taken every cycle (priority write > ack > snooze > tick).
module tod_alarm_ch
    import tod_pkg::*;
#(
    parameter int CW          = 17,
    parameter int SEC_PER_DAY = 86400,
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_SEC  = 300
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          tick_i,           // counter_state_i has just been advanced by a tick
    input  logic [CW-1:0] counter_state_i,
    input  logic          wr_i,
    input  logic [CW-1:0] time_i,
    input  logic          arm_i,
    input  logic          ack_i,
    input  logic          snooze_i,
    output logic          ringing_o
);

    localparam int            RW        = max1_clog2(RING_SEC);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

    alm_state_e    state_q, state_d;
    logic [CW-1:0] setpoint_q, setpoint_d;
    logic [RW-1:0] ring_q, ring_d;
    logic          can_ack;

`ifdef CLOCK_SNOOZE_EN
    localparam logic [CW:0] DAY_W = (CW+1)'(SEC_PER_DAY);
    localparam logic [CW:0] SNZ_W = (CW+1)'(SNOOZE_SEC);

    logic [CW-1:0] target_q, target_d;
    logic [CW:0]   snz_sum;
    logic [CW-1:0] snz_target;

    // The extra bit keeps the sum exact before the single conditional wrap.
    assign snz_sum    = {1'b0, counter_state_i} + SNZ_W;
    assign snz_target = (snz_sum >= DAY_W) ? CW'(snz_sum - DAY_W) : snz_sum[CW-1:0];
    assign can_ack    = (state_q == ALM_RINGING) || (state_q == ALM_SNOOZED);
`else
    logic unused_snooze;
    assign unused_snooze = snooze_i ^ (SNOOZE_SEC == 0) ^ (SEC_PER_DAY == 0);
    assign can_ack       = (state_q == ALM_RINGING);
`endif

    assign ringing_o = (state_q == ALM_RINGING);

    // Channel state register; reset drops any ring immediately.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ALM_IDLE;
            setpoint_q <= '0;
            ring_q     <= '0;
`ifdef CLOCK_SNOOZE_EN
            target_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            setpoint_q <= setpoint_d;
            ring_q     <= ring_d;
`ifdef CLOCK_SNOOZE_EN
            target_q   <= target_d;
`endif
        end
    end

    // Next-state: a write overrides everything, then ack, then snooze, then tick-driven match/timeout.
    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        ring_d     = ring_q;
`ifdef CLOCK_SNOOZE_EN
        target_d   = target_q;
`endif
        if (wr_i) begin
            state_d    = arm_i ? ALM_ARMED : ALM_IDLE;
            setpoint_d = time_i;
            ring_d     = '0;
        end else if (ack_i && can_ack) begin
            state_d = ALM_ARMED;
            ring_d  = '0;
        end
`ifdef CLOCK_SNOOZE_EN
        else if (snooze_i && (state_q == ALM_RINGING)) begin
            state_d  = ALM_SNOOZED;
            target_d = snz_target;
        end
`endif
        else if (tick_i) begin
            case (state_q)
                ALM_ARMED: begin
                    if (counter_state_i == setpoint_q) begin
                        state_d = ALM_RINGING;
                        ring_d  = '0;
                    end
                end
                ALM_RINGING: begin
                    if (ring_q == RING_LAST) begin
                        state_d = ALM_ARMED;
                        ring_d  = '0;
                    end else begin
                        ring_d = ring_q + 1'b1;
                    end
                end
`ifdef CLOCK_SNOOZE_EN
                ALM_SNOOZED: begin
                    if (counter_state_i == target_q) begin
                        state_d = ALM_RINGING;
                        ring_d  = '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tod_counter.sv
// Time-of-day seconds counter with prescaler, set handshake and N alarm channels (snooze: CLOCK_SNOOZE_EN).
// Latency: counter/sec_pulse/day_wrap/set_err registered, 1 cycle; alarm_state 1 cycle after the tick it reacts to.
// Backpressure: set_ready is high whenever reset is low; alarm writes are always accepted.
module tod_counter
    import tod_pkg::*;
#(
    parameter  int CLK_PER_SEC = 4,
    parameter  int SEC_PER_DAY = TOD_SEC_PER_DAY,
    parameter  int N_ALARMS    = 2,
    parameter  int RING_SEC    = 60,
    parameter  int SNOOZE_SEC  = 300,
    localparam int CW          = $clog2(SEC_PER_DAY),
    localparam int AW          = max1_clog2(N_ALARMS)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                run_i,
    input  logic                set_valid_i,
    input  logic [CW-1:0]       set_value_i,
    output logic                set_ready_o,
    output logic                set_err_o,
    input  logic                alm_wr_i,
    input  logic [AW-1:0]       alm_sel_i,
    input  logic [CW-1:0]       alm_time_i,
    input  logic                alm_arm_i,
    input  logic [N_ALARMS-1:0] alm_ack_i,
    input  logic [N_ALARMS-1:0] alm_snooze_i,
    output logic [CW-1:0]       counter_state_o,
    output logic                sec_pulse_o,
    output logic                day_wrap_o,
    output logic [N_ALARMS-1:0] alarm_state_o
);

    localparam int            PW       = max1_clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SEC_PER_DAY - 1);
    localparam logic [CW:0]   DAY_W    = (CW+1)'(SEC_PER_DAY);

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sec_pulse_q, sec_pulse_d;
    logic          day_wrap_q, day_wrap_d;
    logic          set_err_q, set_err_d;
    logic          tick, set_acc, set_ok;

    assign set_ready_o = ~reset_i;
    assign set_acc     = set_valid_i & set_ready_o;
    assign set_ok      = set_acc && ({1'b0, set_value_i} < DAY_W);
    assign tick        = run_i && (presc_q == PRE_LAST);

    // Counter, prescaler and status pulse registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
            set_err_q   <= set_err_d;
        end
    end

    // A valid set beats a same-cycle tick and swallows its sec_pulse; a rejected set leaves the tick alone.
    always_comb begin
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        sec_pulse_d = 1'b0;
        day_wrap_d  = 1'b0;
        set_err_d   = set_acc && !set_ok;
        if (set_ok) begin
            cnt_d   = set_value_i;
            presc_d = '0;
        end else if (tick) begin
            presc_d     = '0;
            sec_pulse_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                day_wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (run_i) begin
            presc_d = presc_q + 1'b1;
        end
    end

    assign counter_state_o = cnt_q;
    assign sec_pulse_o     = sec_pulse_q;
    assign day_wrap_o      = day_wrap_q;
    assign set_err_o       = set_err_q;

    // The registered sec_pulse marks the cycle counter_state first shows a ticked value.
    for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
        tod_alarm_ch #(
            .CW          (CW),
            .SEC_PER_DAY (SEC_PER_DAY),
            .RING_SEC    (RING_SEC),
            .SNOOZE_SEC  (SNOOZE_SEC)
        ) u_ch (
            .clock_i         (clock_i),
            .reset_i         (reset_i),
            .tick_i          (sec_pulse_q),
            .counter_state_i (cnt_q),
            .wr_i            (alm_wr_i && (alm_sel_i == AW'(g))),
            .time_i          (alm_time_i),
            .arm_i           (alm_arm_i),
            .ack_i           (alm_ack_i[g]),
            .snooze_i        (alm_snooze_i[g]),
            .ringing_o       (alarm_state_o[g])
        );
    end

endmodule

// File: tb/tb_tod_counter.sv
// Scoreboard bench for tod_counter: stimulus queues expected output events, a negedge monitor pops and compares.
// An output event is any cycle with sec_pulse, day_wrap, set_err, or a change of alarm_state.
// Built with CLOCK_SNOOZE_EN the snooze scenario expects re-ringing; otherwise it expects the snooze to be ignored.
module tb_tod_counter;

    localparam int CW = 17;
    localparam int NA = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          set_valid = 1'b0;
    logic [CW-1:0] set_value = '0;
    logic          set_ready, set_err;
    logic          alm_wr = 1'b0;
    logic          alm_sel = 1'b0;
    logic [CW-1:0] alm_time = '0;
    logic          alm_arm = 1'b0;
    logic [NA-1:0] alm_ack = '0;
    logic [NA-1:0] alm_snooze = '0;
    logic [CW-1:0] counter_state;
    logic          sec_pulse, day_wrap;
    logic [NA-1:0] alarm_state;

    always #5 clock = ~clock;

    tod_counter #(
        .CLK_PER_SEC (4),
        .SEC_PER_DAY (86400),
        .N_ALARMS    (NA),
        .RING_SEC    (3),
        .SNOOZE_SEC  (5)
    ) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .run_i           (run),
        .set_valid_i     (set_valid),
        .set_value_i     (set_value),
        .set_ready_o     (set_ready),
        .set_err_o       (set_err),
        .alm_wr_i        (alm_wr),
        .alm_sel_i       (alm_sel),
        .alm_time_i      (alm_time),
        .alm_arm_i       (alm_arm),
        .alm_ack_i       (alm_ack),
        .alm_snooze_i    (alm_snooze),
        .counter_state_o (counter_state),
        .sec_pulse_o     (sec_pulse),
        .day_wrap_o      (day_wrap),
        .alarm_state_o   (alarm_state)
    );

    typedef struct {
        logic [CW-1:0] cnt;
        logic          sp;
        logic          dw;
        logic          err;
        logic [NA-1:0] alm;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [NA-1:0] alm_prev = '0;

    task automatic expect_ev(input int c, input logic sp, input logic dw, input logic err, input logic [NA-1:0] alm);
        exp_t e;
        e.cnt = CW'(c);
        e.sp  = sp;
        e.dw  = dw;
        e.err = err;
        e.alm = alm;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_time(input int v);
        set_valid = 1'b1;
        set_value = CW'(v);
        cyc(1);
        set_valid = 1'b0;
    endtask

    task automatic write_alm(input logic ch, input int t, input logic arm);
        alm_wr   = 1'b1;
        alm_sel  = ch;
        alm_time = CW'(t);
        alm_arm  = arm;
        cyc(1);
        alm_wr   = 1'b0;
    endtask

    // Monitor: every output event must match the next queued expectation.
    always @(negedge clock) begin
        if (sec_pulse || day_wrap || set_err || (alarm_state != alm_prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event t=%0t: got cnt=%0d sp=%0b dw=%0b err=%0b alm=%b, expected no event",
                         $time, counter_state, sec_pulse, day_wrap, set_err, alarm_state);
            end else begin
                mon_e = exp_q.pop_front();
                if (counter_state !== mon_e.cnt || sec_pulse !== mon_e.sp || day_wrap !== mon_e.dw ||
                    set_err !== mon_e.err || alarm_state !== mon_e.alm) begin
                    errors++;
                    $display("FAIL event t=%0t: got cnt=%0d sp=%0b dw=%0b err=%0b alm=%b, expected cnt=%0d sp=%0b dw=%0b err=%0b alm=%b",
                             $time, counter_state, sec_pulse, day_wrap, set_err, alarm_state,
                             mon_e.cnt, mon_e.sp, mon_e.dw, mon_e.err, mon_e.alm);
                end
            end
        end
        alm_prev = alarm_state;
    end

    initial begin
        // Reset state
        cyc(3);
        chk("rst_counter", 32'(counter_state), 0);
        chk("rst_sec_pulse", 32'(sec_pulse), 0);
        chk("rst_day_wrap", 32'(day_wrap), 0);
        chk("rst_set_err", 32'(set_err), 0);
        chk("rst_alarm", 32'(alarm_state), 0);
        chk("rst_set_ready", 32'(set_ready), 0);
        reset = 1'b0;
        #1;
        chk("set_ready_up", 32'(set_ready), 1);

        // 40 cycles of run: one tick every 4th cycle
        for (int i = 1; i <= 10; i++) expect_ev(i, 1'b1, 1'b0, 1'b0, 2'b00);
        run = 1'b1;
        cyc(40);
        chk("run40_counter", 32'(counter_state), 10);
        run = 1'b0;

        // Day wrap
        set_time(86398);
        chk("set_86398", 32'(counter_state), 86398);
        expect_ev(86399, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(0,     1'b1, 1'b1, 1'b0, 2'b00);
        expect_ev(1,     1'b1, 1'b0, 1'b0, 2'b00);
        run = 1'b1;
        cyc(12);
        chk("wrap_counter", 32'(counter_state), 1);
        run = 1'b0;

        // Out-of-range set, then set colliding with a tick
        expect_ev(1, 1'b0, 1'b0, 1'b1, 2'b00);
        set_time(86400);
        chk("bad_set_err", 32'(set_err), 1);
        chk("bad_set_counter", 32'(counter_state), 1);
        cyc(1);
        chk("bad_set_err_drop", 32'(set_err), 0);
        run = 1'b1;
        cyc(3);
        set_time(500);
        run = 1'b0;
        chk("set_vs_tick_counter", 32'(counter_state), 500);
        chk("set_vs_tick_no_pulse", 32'(sec_pulse), 0);

        // Channel 1 rings at 100, times out after 3 ticks; channel 0 stays quiet
        write_alm(1'b1, 100, 1'b1);
        set_time(98);
        expect_ev(99,  1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(100, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(100, 1'b0, 1'b0, 1'b0, 2'b10);
        expect_ev(101, 1'b1, 1'b0, 1'b0, 2'b10);
        expect_ev(102, 1'b1, 1'b0, 1'b0, 2'b10);
        expect_ev(103, 1'b1, 1'b0, 1'b0, 2'b10);
        expect_ev(103, 1'b0, 1'b0, 1'b0, 2'b00);
        run = 1'b1;
        cyc(22);
        run = 1'b0;
        chk("ch1_timed_out", 32'(alarm_state), 0);

        // Channel 0: ack + disarm in the same cycle leaves it idle
        write_alm(1'b0, 200, 1'b1);
        set_time(199);
        expect_ev(200, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(200, 1'b0, 1'b0, 1'b0, 2'b01);
        run = 1'b1;
        cyc(6);
        run = 1'b0;
        expect_ev(200, 1'b0, 1'b0, 1'b0, 2'b00);
        alm_ack  = 2'b01;
        alm_wr   = 1'b1;
        alm_sel  = 1'b0;
        alm_time = CW'(200);
        alm_arm  = 1'b0;
        cyc(1);
        alm_ack = 2'b00;
        alm_wr  = 1'b0;
        set_time(199);
        expect_ev(200, 1'b1, 1'b0, 1'b0, 2'b00);
        run = 1'b1;
        cyc(6);
        run = 1'b0;
        chk("ch0_idle_no_ring", 32'(alarm_state), 0);

        // Re-ring channel 0, then reset mid-ring
        write_alm(1'b0, 200, 1'b1);
        set_time(199);
        expect_ev(200, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(200, 1'b0, 1'b0, 1'b0, 2'b01);
        run = 1'b1;
        cyc(6);
        expect_ev(0, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        run   = 1'b0;
        #2;
        chk("midring_rst_counter", 32'(counter_state), 0);
        chk("midring_rst_alarm", 32'(alarm_state), 0);
        chk("midring_rst_set_ready", 32'(set_ready), 0);
        cyc(2);
        reset = 1'b0;

        // Snooze across midnight
        write_alm(1'b0, 86398, 1'b1);
        set_time(86397);
        expect_ev(86398, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(86398, 1'b0, 1'b0, 1'b0, 2'b01);
`ifdef CLOCK_SNOOZE_EN
        expect_ev(86398, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_ev(86399, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(0,     1'b1, 1'b1, 1'b0, 2'b00);
        expect_ev(1,     1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(2,     1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(3,     1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(3,     1'b0, 1'b0, 1'b0, 2'b01);
`else
        expect_ev(86399, 1'b1, 1'b0, 1'b0, 2'b01);
        expect_ev(0,     1'b1, 1'b1, 1'b0, 2'b01);
        expect_ev(1,     1'b1, 1'b0, 1'b0, 2'b01);
        expect_ev(1,     1'b0, 1'b0, 1'b0, 2'b00);
        expect_ev(2,     1'b1, 1'b0, 1'b0, 2'b00);
        expect_ev(3,     1'b1, 1'b0, 1'b0, 2'b00);
`endif
        run = 1'b1;
        cyc(5);
        alm_snooze = 2'b01;
        cyc(1);
        alm_snooze = 2'b00;
        cyc(19);
        run = 1'b0;
`ifdef CLOCK_SNOOZE_EN
        chk("snooze_rerang", 32'(alarm_state), 1);
        expect_ev(3, 1'b0, 1'b0, 1'b0, 2'b00);
        alm_ack = 2'b01;
        cyc(1);
        alm_ack = 2'b00;
`endif
        chk("snooze_final_counter", 32'(counter_state), 3);
        chk("snooze_final_alarm", 32'(alarm_state), 0);

        cyc(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
